// File: rtl/ram_ctrl.sv
// Bus initiator for the 1K x 8 synchronous RAM: turns single/burst read and write commands into cs/rd/wr cycles.
// Optional build macro RAM_CTRL_VERIFY_EN adds a read-back check after every write beat, reported on err.
module ram_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          cs,
  output logic          rd,
  output logic          wr
);

  typedef enum logic [2:0] {
    IDLE,
    WGET,
    WR,
    RD_A,
    RD_B
`ifdef RAM_CTRL_VERIFY_EN
    , VR_A,
    VR_B
`endif
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr_d;
  logic [LW-1:0] cnt, cnt_d;
  logic          cs_d, rd_d, wr_d, oe, oe_d;
  logic [DW-1:0] wbuf, wbuf_d;
  logic [DW-1:0] rdata_d;
  logic          rvalid_d, done_d;
  logic          last_beat;

  // Burst addresses roll over the top of the RAM rather than saturating.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return a + 1'b1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign wready    = (state == WGET);
  assign last_beat = (cnt == '0);
  assign data      = oe ? wbuf : {DW{1'bz}};

`ifdef RAM_CTRL_VERIFY_EN
  logic err_d;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    cnt_d    = cnt;
    cs_d     = cs;
    rd_d     = rd;
    wr_d     = wr;
    oe_d     = oe;
    wbuf_d   = wbuf;
    rdata_d  = rdata;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
    err_d    = err;
`endif
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
`ifdef RAM_CTRL_VERIFY_EN
          err_d  = 1'b0;
`endif
          if (cmd_we) begin
            state_d = WGET;
          end else begin
            state_d = RD_A;
            cs_d    = 1'b1;
            rd_d    = 1'b1;
          end
        end
      end
      WGET: begin
        if (wvalid) begin
          wbuf_d  = wdata;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          oe_d    = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        wr_d = 1'b0;
        oe_d = 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
        rd_d    = 1'b1;
        state_d = VR_A;
`else
        cs_d = 1'b0;
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - 1'b1;
          addr_d  = next_addr(addr);
          state_d = WGET;
        end
`endif
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        rdata_d  = data;
        rvalid_d = 1'b1;
        if (last_beat) begin
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - 1'b1;
          addr_d  = next_addr(addr);
          state_d = RD_A;
        end
      end
`ifdef RAM_CTRL_VERIFY_EN
      VR_A: state_d = VR_B;
      VR_B: begin
        // Read-back of the byte just written; mismatch latches until the next command.
        if (data != wbuf) err_d = 1'b1;
        cs_d = 1'b0;
        rd_d = 1'b0;
        if (last_beat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - 1'b1;
          addr_d  = next_addr(addr);
          state_d = WGET;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      cs     <= 1'b0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      oe     <= 1'b0;
      rdata  <= '0;
      rvalid <= 1'b0;
      done   <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
      err    <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      addr   <= addr_d;
      cnt    <= cnt_d;
      cs     <= cs_d;
      rd     <= rd_d;
      wr     <= wr_d;
      oe     <= oe_d;
      rdata  <= rdata_d;
      rvalid <= rvalid_d;
      done   <= done_d;
`ifdef RAM_CTRL_VERIFY_EN
      err    <= err_d;
`endif
    end
  end

  // Write holding register is pure data and needs no reset.
  always_ff @(posedge clk) begin
    wbuf <= wbuf_d;
  end

endmodule
